// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: keyboard command bytes, host-transmit error codes
// and the host transmitter state encoding.
package ps2_pkg;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_START_TO = 2'b01,
    ERR_PKT_TO   = 2'b10,
    ERR_NO_ACK   = 2'b11
  } ps2_err_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_BITS,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_ERR
  } ps2_tx_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Conditions the raw PS/2 pads: 2-FF synchronisers on clock and data, a
// consecutive-sample glitch filter on the clock, and a one-cycle fall strobe.
module ps2_line_sync #(
  parameter int FILTER = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_raw,
  input  logic dat_raw,
  output logic clk_filt,
  output logic dat_sync,
  output logic clk_fall
);

  localparam int CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

  logic [1:0]    clk_meta;
  logic [1:0]    dat_meta;
  logic [CW-1:0] cnt;

  assign dat_sync = dat_meta[1];

  // A new clock level is accepted only after FILTER consecutive differing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta <= 2'b11;
      dat_meta <= 2'b11;
      clk_filt <= 1'b1;
      cnt      <= '0;
      clk_fall <= 1'b0;
    end else begin
      clk_meta <= {clk_meta[0], clk_raw};
      dat_meta <= {dat_meta[0], dat_raw};
      clk_fall <= 1'b0;
      if (clk_meta[1] == clk_filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        clk_filt <= clk_meta[1];
        clk_fall <= clk_filt;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then
// shifts one command byte out on device clock falls and checks the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC  = 5000,
  parameter int START_TO_CYC = 750000,
  parameter int PKT_TO_CYC   = 100000,
  parameter int FILTER       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int TW = $clog2(max3(INHIBIT_CYC, START_TO_CYC, PKT_TO_CYC) + 1);
  localparam logic [TW-1:0] INH_DAT    = TW'(INHIBIT_CYC - 2);
  localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TO_CYC - 1);
  localparam logic [TW-1:0] PKT_LAST   = TW'(PKT_TO_CYC - 1);

  ps2_tx_state_t state;
  ps2_err_t      err_q;
  logic [9:0]    shift;
  logic [3:0]    bitcnt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;
  logic          clk_filt;
  logic          dat_sync;
  logic          clk_fall;

  assign err_code  = err_q;
  assign timer_inc = (&timer) ? timer : timer + 1'b1;

  ps2_line_sync #(.FILTER(FILTER)) u_line_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_raw  (ps2_clk_i),
    .dat_raw  (ps2_dat_i),
    .clk_filt (clk_filt),
    .dat_sync (dat_sync),
    .clk_fall (clk_fall)
  );

  // Timeouts are checked before the fall strobe so expiry wins a tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      err_q      <= ERR_NONE;
      shift      <= '0;
      bitcnt     <= '0;
      timer      <= '0;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      busy       <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_ready   <= 1'b1;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (tx_valid && tx_ready) begin
            shift      <= {1'b1, ~^tx_data, tx_data};
            err_q      <= ERR_NONE;
            timer      <= '0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state      <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          timer <= timer_inc;
          if (timer == INH_DAT) ps2_dat_oe <= 1'b1;
          if (timer == INH_LAST) begin
            ps2_clk_oe <= 1'b0;
            timer      <= '0;
            state      <= ST_RTS;
          end
        end
        ST_RTS: begin
          timer <= timer_inc;
          if (timer == START_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            err_q      <= ERR_START_TO;
            tx_err     <= 1'b1;
            state      <= ST_ERR;
          end else if (clk_fall) begin
            ps2_dat_oe <= ~shift[0];
            bitcnt     <= 4'd1;
            timer      <= '0;
            state      <= ST_BITS;
          end
        end
        ST_BITS, ST_ACK, ST_WAIT_IDLE: begin
          timer <= timer_inc;
          if (timer >= PKT_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            err_q      <= ERR_PKT_TO;
            tx_err     <= 1'b1;
            state      <= ST_ERR;
          end else if (state == ST_BITS) begin
            if (clk_fall) begin
              ps2_dat_oe <= ~shift[bitcnt];
              bitcnt     <= bitcnt + 4'd1;
              if (bitcnt == 4'd9) state <= ST_ACK;
            end
          end else if (state == ST_ACK) begin
            if (clk_fall) begin
              if (dat_sync) begin
                ps2_dat_oe <= 1'b0;
                err_q      <= ERR_NO_ACK;
                tx_err     <= 1'b1;
                state      <= ST_ERR;
              end else begin
                state <= ST_WAIT_IDLE;
              end
            end
          end else if (clk_filt && dat_sync) begin
            tx_done <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_ERR: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example ED (set LEDs), FF (reset) or F4 (enable), over the same PS2_CLK/PS2_DAT pair the existing receiver listens on. It drives both lines open-drain through output enables; the top level ties each pad to 1'b0 when its enable is high and to z otherwise. It runs in the 50 MHz domain alongside the PS/2 receiver and raises busy so the receiver ignores the line during a host transfer.

Parameters:
INHIBIT_CYC, 5000, clock-low hold before request-to-send (100 us at 50 MHz).
START_TO_CYC, 750000, maximum wait from clock release to the first device falling edge (15 ms).
PKT_TO_CYC, 100000, maximum time from the first falling edge to the ack (2 ms).
FILTER, 4, number of consecutive equal synchronised samples required to accept a ps2_clk level change.

Ports:
clk  in  1  system clock, 50 MHz.
reset_n  in  1  asynchronous, active-low reset.
tx_data  in  8  command byte.
tx_valid  in  1  request; the byte is accepted when tx_valid and tx_ready are both high.
tx_ready  out  1  high only in IDLE.
tx_done  out  1  one-cycle pulse on a successful, acked transfer.
tx_err  out  1  one-cycle pulse on a failed transfer.
err_code  out  2  01 start timeout, 10 packet timeout, 11 no ack; holds until the next acceptance.
busy  out  1  high in every state other than IDLE.
ps2_clk_i  in  1  raw PS2_CLK pad level.
ps2_dat_i  in  1  raw PS2_DAT pad level.
ps2_clk_oe  out  1  1 pulls PS2_CLK low.
ps2_dat_oe  out  1  1 pulls PS2_DAT low.

Behaviour:
- Reset:
  - Outputs are released asynchronously: oe=0, tx_ready=1, busy=0, tx_done=0, tx_err=0, err_code=00.
  - Reset asserted mid-transfer abandons the frame immediately, with no pulse.
- Input conditioning:
  - Both pad inputs go through a 2-FF synchroniser.
  - ps2_clk additionally passes the FILTER glitch filter.
  - fall = filtered clock 1 -> 0, one-cycle strobe.
- Acceptance:
  - Captures shift = {1'b1 stop, ~^tx_data odd parity, tx_data}, 10 bits, LSB first.
  - Clears err_code and enters INHIBIT on the next cycle.
- States:
  - IDLE: oe=00, tx_ready=1.
  - INHIBIT: ps2_clk_oe=1 for INHIBIT_CYC cycles. In the last cycle assert ps2_dat_oe=1 (start bit 0), then go to RTS.
  - RTS:
    - ps2_clk_oe=0, ps2_dat_oe held at 1, timer counts.
    - fall -> drive shift[0] (ps2_dat_oe = ~shift[0]), set bitcnt=1, restart the timer for PKT_TO_CYC, go to BITS.
    - Timer reaching START_TO_CYC -> ERR with code 01.
  - BITS:
    - On each fall, drive shift[bitcnt] and increment bitcnt.
    - The fall that drives bit 9 (stop = 1) releases the data line; then go to ACK.
  - ACK:
    - On the next fall, sample synchronised ps2_dat. 0 -> WAIT_IDLE; 1 -> ERR with code 11.
  - WAIT_IDLE: wait until filtered clock and data are both 1, then pulse tx_done and go to IDLE.
  - ERR: oe=00, pulse tx_err, go to IDLE.
- Packet timeout:
  - The PKT_TO_CYC timer runs from the first fall through BITS, ACK and WAIT_IDLE.
  - Expiry -> ERR with code 10 in any of those states.
- Data-change rule: data changes only in the cycle after fall, so it is stable before the device samples on the rising edge.
- tx_valid during busy is ignored; no queue. The master must hold tx_valid until it sees tx_ready.
- Simultaneous events:
  - Timer expiry and fall in the same cycle: the timeout wins.
  - tx_done and the next acceptance cannot coincide, because tx_ready is low in WAIT_IDLE.
- Timer width: $clog2(START_TO_CYC+1); it saturates and never wraps.

Decomposition:
- Shared package ps2_pkg:
  - Command constants CMD_SET_LED=8'hED, CMD_ECHO=8'hEE, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF.
  - err_code enum values.
  - State encoding.
- One sub-module, ps2_line_sync: 2-FF synchroniser plus FILTER glitch filter plus fall strobe. It is reusable by the receiver.

Test Plan:
- Send 8'hED with device model ack, INHIBIT_CYC=20 for sim:
  - Clock low for 20 cycles, then data low.
  - Bits sampled on device rising edges: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Ack 0 -> tx_done pulse, err_code 00.
- Send 8'hF4:
  - Parity bit 0 (five ones).
  - tx_ready low from acceptance until the cycle after tx_done.
- Device never clocks, START_TO_CYC=200 -> tx_err pulse 200 cycles after clock release, err_code 01, both oe 0.
- Device leaves data high at the ack clock -> tx_err, err_code 11.
- Device stops clocking after 4 falls, PKT_TO_CYC=300 -> tx_err, err_code 10.
- Inject a 2-cycle clock glitch during BITS -> no bit advance.
- reset_n low mid-BITS:
  - Both oe drop asynchronously and tx_ready returns to 1.
  - A following 8'hFF send completes with parity 1.
